// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants and grant-decode helpers for the arbiter
//                and its downstream blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int N_CLIENTS = 8;
   localparam int ID_W      = 3;

   // OR-reduction encoder; only meaningful for a one-hot input.
   function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_CLIENTS-1:0] oh);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (oh[i]) idx = idx | ID_W'(i);
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input logic [N_CLIENTS-1:0] v);
      return (v != '0) && ((v & (v - N_CLIENTS'(1))) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered pointers and occupancy
//                count; read data is the registered head (no fall-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;

   // Popping an empty FIFO is ignored so the count can never underflow.
   assign w_do_pop = pop && (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(push) - CNT_W'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= wdata;
   end

   assign rdata = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == c_depth);
   assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gnt_to_stream.sv
`default_nettype none
// ============================================================================
//  Module      : gnt_to_stream
//  Description : Captures the granted client word into a FIFO, presents it
//                as a valid/ready stream, and drives ack/stall back upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module gnt_to_stream
   import arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_CLIENTS-1:0]          gnt,
   input  logic [N_CLIENTS*DATA_W-1:0]   cl_data,
   output logic [N_CLIENTS-1:0]          ack,
   output logic                          stall,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic [ID_W-1:0]               out_id,
   input  logic                          out_ready,
   output logic                          onehot_err,
   output logic                          overflow_err
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = ID_W + DATA_W;
   localparam logic [CNT_W-1:0] c_stall_lvl = CNT_W'(DEPTH - 1);

   logic                 w_onehot;
   logic                 w_multi;
   logic [ID_W-1:0]      w_idx;
   logic [DATA_W-1:0]    w_data;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_full;
   logic                 w_empty;
   logic [CNT_W-1:0]     w_count;
   logic [ENT_W-1:0]     w_rdata;
   logic [N_CLIENTS-1:0] r_ack;
   logic                 r_onehot_err;
   logic                 r_overflow_err;

   assign w_onehot = is_onehot(gnt);
   assign w_multi  = (gnt != '0) && !w_onehot;
   assign w_idx    = onehot_to_idx(gnt);

   // AND-OR mux keyed directly on the grant bits.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (gnt[i]) w_data = w_data | cl_data[i*DATA_W +: DATA_W];
      end
   end

   assign w_pop  = out_valid && out_ready;
   assign w_push = w_onehot && (!w_full || w_pop);

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .wdata ({w_idx, w_data}),
      .rdata (w_rdata),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack          <= '0;
         r_onehot_err   <= 1'b0;
         r_overflow_err <= 1'b0;
      end else begin
         r_ack <= w_push ? (N_CLIENTS'(1) << w_idx) : '0;
         if (w_multi) r_onehot_err <= 1'b1;
         if (w_onehot && w_full && !w_pop) r_overflow_err <= 1'b1;
      end
   end

   // One slot of headroom covers the single grant already in flight.
   assign stall        = (w_count >= c_stall_lvl);
   assign out_valid    = !w_empty;
   assign out_id       = w_rdata[ENT_W-1 -: ID_W];
   assign out_data     = w_rdata[DATA_W-1:0];
   assign ack          = r_ack;
   assign onehot_err   = r_onehot_err;
   assign overflow_err = r_overflow_err;

endmodule
`default_nettype wire
